// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory write port,
// little-endian, one byte per cycle, holding the CPU while an image is loaded.
//
// state  | meaning
// IDLE   | preloaded ROM image runs, loader inactive
// ACCEPT | waiting for the next word on the stream
// WRITE  | emitting the buffered word, one byte per cycle
// DONE   | image loaded, CPU released
// ERROR  | image overran memory, CPU held until restart
module imem_loader #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int BASE_ADDR     = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [DATA_WIDTH-1:0]    wdata_i,
   input  logic                     wvalid_i,
   input  logic                     wlast_i,
   output logic                     wready_o,
   output logic                     mem_we_o,
   output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
   output logic [7:0]               mem_byte_o,
   output logic                     cpu_hold_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_WRITE  = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   localparam logic [ADDRESS_WIDTH-1:0] ADDR_BASE = ADDRESS_WIDTH'(BASE_ADDR);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_TOP  = '1;

   logic [2:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    buf_q, buf_d;
   logic                     last_q, last_d;
   logic [1:0]               idx_q, idx_d;
   logic                     final_byte;

   assign final_byte = (idx_q == 2'd3) && last_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      last_d  = last_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d = S_ACCEPT;
               addr_d  = ADDR_BASE;
            end
         end
         S_ACCEPT: begin
            if (wvalid_i) begin
               buf_d   = wdata_i;
               last_d  = wlast_i;
               idx_d   = 2'd0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            idx_d = idx_q + 2'd1;
            if (final_byte) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_TOP) begin
               state_d = S_ERROR;
            end else if (idx_q == 2'd3) begin
               state_d = S_ACCEPT;
            end
            // Saturate at the top address so an overrun can never wrap onto address 0.
            if (addr_q != ADDR_TOP) begin
               addr_d = addr_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= ADDR_BASE;
         buf_q   <= '0;
         last_q  <= 1'b0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
      end
   end

   assign wready_o   = (state_q == S_ACCEPT);
   assign mem_we_o   = (state_q == S_WRITE);
   assign mem_addr_o = addr_q;
   assign mem_byte_o = buf_q[{idx_q, 3'b000} +: 8];
   assign busy_o     = (state_q == S_ACCEPT) || (state_q == S_WRITE);
   assign cpu_hold_o = busy_o || (state_q == S_ERROR);
   assign done_o     = (state_q == S_DONE);
   assign err_o      = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, back-to-back, full-memory fill,
// overflow, mid-write reset, start during write and gapped valid.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] wdata_i;
   logic        wvalid_i;
   logic        wlast_i;
   logic        wready_o;
   logic        mem_we_o;
   logic [7:0]  mem_addr_o;
   logic [7:0]  mem_byte_o;
   logic        cpu_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [256];
   int         wr_count = 0;
   int         snap;
   logic [31:0] rd;
   logic [31:0] words3 [3];

   imem_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .wdata_i    (wdata_i),
      .wvalid_i   (wvalid_i),
      .wlast_i    (wlast_i),
      .wready_o   (wready_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_byte_o (mem_byte_o),
      .cpu_hold_o (cpu_hold_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   // Instruction memory model: commits on the edge that ends a write cycle.
   always @(posedge clk) begin
      if (mem_we_o) begin
         mem[mem_addr_o] <= mem_byte_o;
         wr_count        <= wr_count + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_session();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("start_wready", {31'd0, wready_o}, 32'd1);
   endtask

   // Presents one word (after `gap` idle cycles), waits for the handshake and
   // checks the four byte writes that follow.
   task automatic send_word(input logic [31:0] d, input logic l, input logic [7:0] a0,
                            input bit keep_valid, input int gap, input bit pulse_start);
      int n;
      wdata_i = d;
      wlast_i = l;
      for (int g = 0; g < gap; g++) begin
         wvalid_i = 1'b0;
         step();
         chk("gap_no_we", {31'd0, mem_we_o}, 32'd0);
      end
      wvalid_i = 1'b1;
      n = 0;
      while (!wready_o && n < 20) begin
         step();
         n++;
      end
      chk("wready_wait", {31'd0, wready_o}, 32'd1);
      step();
      if (!keep_valid) wvalid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("we",     {31'd0, mem_we_o}, 32'd1);
         chk("addr",   {24'd0, mem_addr_o}, {24'd0, a0 + 8'(i)});
         chk("byte",   {24'd0, mem_byte_o}, {24'd0, d[8*i +: 8]});
         chk("hold",   {31'd0, cpu_hold_o}, 32'd1);
         chk("wr_rdy", {31'd0, wready_o}, 32'd0);
         start_i = pulse_start && (i == 1);
         step();
      end
      start_i = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start_i  = 1'b0;
      wdata_i  = '0;
      wvalid_i = 1'b0;
      wlast_i  = 1'b0;
      step();
      step();
      chk("rst_wready", {31'd0, wready_o}, 32'd0);
      chk("rst_we",     {31'd0, mem_we_o}, 32'd0);
      chk("rst_addr",   {24'd0, mem_addr_o}, 32'd0);
      chk("rst_byte",   {24'd0, mem_byte_o}, 32'd0);
      chk("rst_hold",   {31'd0, cpu_hold_o}, 32'd0);
      chk("rst_busy",   {31'd0, busy_o}, 32'd0);
      chk("rst_done",   {31'd0, done_o}, 32'd0);
      chk("rst_err",    {31'd0, err_o}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_hold", {31'd0, cpu_hold_o}, 32'd0);

      // Single word, last.
      start_session();
      chk("acc_busy", {31'd0, busy_o}, 32'd1);
      chk("acc_hold", {31'd0, cpu_hold_o}, 32'd1);
      send_word(32'h0050_0093, 1'b1, 8'h00, 1'b0, 0, 1'b0);
      chk("w1_done", {31'd0, done_o}, 32'd1);
      chk("w1_hold", {31'd0, cpu_hold_o}, 32'd0);
      chk("w1_busy", {31'd0, busy_o}, 32'd0);
      chk("w1_err",  {31'd0, err_o}, 32'd0);
      rd = {mem[3], mem[2], mem[1], mem[0]};
      chk("w1_read", rd, 32'h0050_0093);

      // Three back-to-back words with wvalid held.
      words3[0] = 32'h1122_3344;
      words3[1] = 32'hA5A5_0F0F;
      words3[2] = 32'hDEAD_BEEF;
      start_session();
      snap = wr_count;
      for (int w = 0; w < 3; w++) begin
         send_word(words3[w], w == 2, 8'(4 * w), 1'b1, 0, 1'b0);
         chk("b2b_done", {31'd0, done_o}, (w == 2) ? 32'd1 : 32'd0);
      end
      wvalid_i = 1'b0;
      chk("b2b_count", 32'(wr_count - snap), 32'd12);
      rd = {mem[11], mem[10], mem[9], mem[8]};
      chk("b2b_read", rd, 32'hDEAD_BEEF);

      // Full fill, last on the 64th word.
      start_session();
      for (int w = 0; w < 64; w++) begin
         send_word(32'(w) * 32'h0101_0101 ^ 32'h3C00_00C3, w == 63, 8'(4 * w), 1'b0, 0, 1'b0);
      end
      chk("full_done", {31'd0, done_o}, 32'd1);
      chk("full_err",  {31'd0, err_o}, 32'd0);
      rd = {mem[255], mem[254], mem[253], mem[252]};
      chk("full_top", rd, 32'(63) * 32'h0101_0101 ^ 32'h3C00_00C3);

      // Overflow: 64 words, none marked last.
      start_session();
      for (int w = 0; w < 64; w++) begin
         send_word(32'hC0DE_0000 | 32'(w), 1'b0, 8'(4 * w), 1'b0, 0, 1'b0);
      end
      snap = wr_count;
      chk("ovf_err",   {31'd0, err_o}, 32'd1);
      chk("ovf_done",  {31'd0, done_o}, 32'd0);
      chk("ovf_hold",  {31'd0, cpu_hold_o}, 32'd1);
      chk("ovf_busy",  {31'd0, busy_o}, 32'd0);
      chk("ovf_wrdy",  {31'd0, wready_o}, 32'd0);
      chk("ovf_we",    {31'd0, mem_we_o}, 32'd0);
      wvalid_i = 1'b1;
      step();
      step();
      step();
      wvalid_i = 1'b0;
      chk("ovf_nowr",  32'(wr_count - snap), 32'd0);
      chk("ovf_err2",  {31'd0, err_o}, 32'd1);
      chk("ovf_top",   {24'd0, mem[255]}, 32'h0000_00C0);
      start_session();
      chk("ovf_clr",   {31'd0, err_o}, 32'd0);
      send_word(32'h0BAD_F00D, 1'b1, 8'h00, 1'b0, 0, 1'b0);
      chk("ovf_reload_done", {31'd0, done_o}, 32'd1);

      // Start pulsed mid-write has no effect.
      start_session();
      send_word(32'h89AB_CDEF, 1'b0, 8'h00, 1'b0, 0, 1'b1);
      chk("st_wrdy", {31'd0, wready_o}, 32'd1);
      send_word(32'h7654_3210, 1'b1, 8'h04, 1'b0, 0, 1'b0);
      chk("st_done", {31'd0, done_o}, 32'd1);

      // Reset during WRITE at idx=1.
      start_session();
      wdata_i  = 32'hCAFE_F00D;
      wlast_i  = 1'b0;
      wvalid_i = 1'b1;
      step();
      wvalid_i = 1'b0;
      step();
      chk("mr_idx1_addr", {24'd0, mem_addr_o}, 32'd1);
      chk("mr_idx1_byte", {24'd0, mem_byte_o}, 32'h0000_00F0);
      rst_n = 1'b0;
      step();
      snap = wr_count;
      rst_n = 1'b1;
      chk("mr_we",    {31'd0, mem_we_o}, 32'd0);
      chk("mr_addr",  {24'd0, mem_addr_o}, 32'd0);
      chk("mr_byte",  {24'd0, mem_byte_o}, 32'd0);
      chk("mr_wrdy",  {31'd0, wready_o}, 32'd0);
      chk("mr_hold",  {31'd0, cpu_hold_o}, 32'd0);
      chk("mr_busy",  {31'd0, busy_o}, 32'd0);
      chk("mr_done",  {31'd0, done_o}, 32'd0);
      chk("mr_err",   {31'd0, err_o}, 32'd0);
      step();
      step();
      step();
      chk("mr_nowr",  32'(wr_count - snap), 32'd0);
      chk("mr_idle",  {31'd0, busy_o}, 32'd0);

      // Gapped valid: same addresses and bytes as the gapless run.
      start_session();
      snap = wr_count;
      for (int w = 0; w < 3; w++) begin
         send_word(words3[w], w == 2, 8'(4 * w), 1'b0, 6, 1'b0);
      end
      chk("gap_count", 32'(wr_count - snap), 32'd12);
      chk("gap_done",  {31'd0, done_o}, 32'd1);
      rd = {mem[7], mem[6], mem[5], mem[4]};
      chk("gap_read",  rd, 32'hA5A5_0F0F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the byte-addressed instruction ROM. Accepts 32-bit instruction words over a valid/ready stream and writes them, one byte per cycle in little-endian order, into the byte-wide write port of the instruction memory array. The instruction memory read path reassembles each instruction as `{mem[a+3], mem[a+2], mem[a+1], mem[a]}`. This block holds the CPU while a program image is loaded and reports completion or address overflow.

## Interface
- ADDRESS_WIDTH, 8, byte address width of instruction memory (2**ADDRESS_WIDTH bytes)
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- BASE_ADDR, 0, first byte address written after `start_i`; any value in range, alignment not required

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  begin a load session (sampled only in IDLE, DONE, ERROR)
- wdata_i  in  DATA_WIDTH  instruction word
- wvalid_i  in  1  wdata_i/wlast_i valid
- wlast_i  in  1  this word is the final word of the image
- wready_o  out  1  block can accept a word this cycle
- mem_we_o  out  1  byte write strobe to instruction memory
- mem_addr_o  out  ADDRESS_WIDTH  byte write address
- mem_byte_o  out  8  byte write data
- cpu_hold_o  out  1  keep CPU/PC in reset while high
- busy_o  out  1  load session in progress
- done_o  out  1  last image loaded without error
- err_o  out  1  image exceeded memory; load aborted

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERROR. All outputs are decoded from registered state (Moore); none depend combinationally on inputs.
- Registers: state, addr (ADDRESS_WIDTH), word buffer (32), last flag, byte index idx (2 bits).
- IDLE: `wready_o`=0, `cpu_hold_o`=0. The preloaded ROM image runs. `start_i`=1 → ACCEPT, addr←BASE_ADDR.
- ACCEPT: `wready_o`=1, `busy_o`=1, `cpu_hold_o`=1. A handshake is `wvalid_i & wready_o`. On a handshake: buffer←wdata_i, last←wlast_i, idx←0, → WRITE. With no handshake, remain in ACCEPT indefinitely.
- WRITE: `wready_o`=0, `mem_we_o`=1, `mem_addr_o`=addr, `mem_byte_o`=buffer[8*idx +: 8], `busy_o`=1, `cpu_hold_o`=1. Each cycle: idx←idx+1, addr←addr+1.
  - idx=3 and last=1 → DONE.
  - idx=3 and last=0 → ACCEPT.
- Overflow: in WRITE with addr = all-ones, if the byte being written is not (idx=3 and last=1), → ERROR next cycle. That byte is still written. addr never wraps to 0, so there is no write at address 0 after 2**ADDRESS_WIDTH−1.
- DONE: `done_o`=1, `cpu_hold_o`=0, `busy_o`=0. `start_i` → ACCEPT, addr←BASE_ADDR (reload).
- ERROR: `err_o`=1, `cpu_hold_o`=1, `busy_o`=0, `wready_o`=0. Leaves only on `start_i` (→ ACCEPT, addr←BASE_ADDR) or reset.
- `start_i` is ignored in ACCEPT and WRITE.
- `done_o` and `err_o` are mutually exclusive.
- `mem_addr_o` and `mem_byte_o` are don't-care when `mem_we_o`=0. They must not be X in simulation; drive addr and buffer bits.

## Timing
- Reset (rst_n=0 at a rising edge): state←IDLE, addr←BASE_ADDR, idx←0, buffer←0, last←0. Reset wins over every other input in the same cycle, including mid-WRITE; a partially written word is abandoned.
- Output reset values: `wready_o`=0, `mem_we_o`=0, `mem_addr_o`=BASE_ADDR, `mem_byte_o`=0, `cpu_hold_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0.
- `start_i` sampled at edge E: `wready_o`=1 in the cycle after E.
- Handshake at edge H: byte0 strobe during cycle H+1, byte3 during H+4. `wready_o` returns high during H+5 (non-last word). Sustained throughput is 1 word per 5 cycles.
- Last word handshake at H: `done_o`=1 and `cpu_hold_o`=0 from cycle H+5.
- Memory commits the byte on the rising edge that ends a `mem_we_o` cycle.

## Test plan
- Reset, then `start_i`, then one word 0x00500093 with wlast_i=1 (BASE_ADDR=0) → bytes 0x93,0x00,0x50,0x00 at addresses 0,1,2,3 on 4 consecutive cycles; `done_o`=1 five cycles after the handshake; a read of address 0 returns 0x00500093.
- Three back-to-back words, wvalid_i held high → exactly 12 consecutive-address writes; `wready_o` high 1 cycle in 5; `cpu_hold_o`=1 throughout; `done_o` after the third word only.
- ADDRESS_WIDTH=8: 64 words, last on the 64th → final write at 0xFF; `done_o`=1, `err_o`=0.
- ADDRESS_WIDTH=8: 64 words, wlast_i=0 on the 64th → write at 0xFF occurs; `err_o`=1 next cycle; no write to 0x00; `cpu_hold_o` stays 1; a subsequent `start_i` returns to ACCEPT at BASE_ADDR.
- rst_n=0 during WRITE at idx=1 → next cycle all outputs at reset values and no further `mem_we_o`. `start_i` pulsed during WRITE → no effect on addr or state.
- wvalid_i gapped (asserted every 7th cycle) → no write occurs without a handshake; byte order and addresses are identical to the gapless case.
